// File: rtl/step_count_decoder.sv
// Receive-side decoder for the dual-step up/down counter: recovers linear index, direction and protocol errors.
// Optional run-length output enabled by defining STEP_DECODE_RUNLEN_EN.
module step_count_decoder #(
  parameter int WIDTH   = 16,
  parameter int CUTLINE = 15,
  parameter int AB_SH   = 1,
  parameter int ECNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              din_vld,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  idx,
  output logic [1:0]        dir,
  output logic              out_vld,
  output logic              err,
  output logic [ECNT_W-1:0] err_cnt
`ifdef STEP_DECODE_RUNLEN_EN
  ,
  output logic [WIDTH-1:0]  run_len
`endif
);

  localparam logic [WIDTH-1:0] CUT      = WIDTH'(CUTLINE);
  localparam logic [WIDTH-1:0] AB       = WIDTH'(1) << AB_SH;
  localparam logic [WIDTH-1:0] GRID_MSK = AB - WIDTH'(1);

  typedef enum logic {ACQ, TRACK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] ofs, idx_nxt, up_stp, dn_stp;
  logic             above, offgrid, is_up, is_dn, delta_err, evt;
  logic [1:0]       dir_nxt;

  assign above   = din > CUT;
  assign ofs     = din - CUT;
  assign idx_nxt = above ? (ofs >> AB_SH) + CUT : din;
  assign offgrid = above && (|(ofs & GRID_MSK));
  assign up_stp  = (prev <  CUT) ? WIDTH'(1) : AB;
  assign dn_stp  = (prev <= CUT) ? WIDTH'(1) : AB;
  // One extra bit keeps a wrap through 0 / all-ones from looking like a step
  assign is_up   = ({1'b0, prev} + {1'b0, up_stp}) == {1'b0, din};
  assign is_dn   = ({1'b0, din}  + {1'b0, dn_stp}) == {1'b0, prev};

  always_ff @(posedge clk) begin
    if (rst) state <= ACQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = 2'b11;
    delta_err = 1'b0;
    if (din_vld) begin
      case (state)
        ACQ:   state_nxt = TRACK;
        TRACK: begin
          if (din == prev) dir_nxt = 2'b00;
          else if (is_up)  dir_nxt = 2'b01;
          else if (is_dn)  dir_nxt = 2'b10;
          else             delta_err = 1'b1;
        end
        default: state_nxt = ACQ;
      endcase
    end
  end

  assign evt = din_vld && (delta_err || offgrid);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      dir     <= 2'b11;
      out_vld <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      prev    <= '0;
    end else begin
      out_vld <= din_vld;
      if (din_vld) begin
        idx  <= idx_nxt;
        dir  <= dir_nxt;
        prev <= din;
      end
      // A same-cycle error event beats err_clr
      if (evt) begin
        err     <= 1'b1;
        err_cnt <= err_clr ? ECNT_W'(1) : (&err_cnt ? err_cnt : err_cnt + ECNT_W'(1));
      end else if (err_clr) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
    end
  end

`ifdef STEP_DECODE_RUNLEN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_len <= '0;
    end else if (din_vld) begin
      if (state == ACQ || evt)                  run_len <= '0;
      else if (dir_nxt == dir && run_len != '0) run_len <= &run_len ? run_len : run_len + WIDTH'(1);
      else                                      run_len <= WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_step_count_decoder.sv
// Directed self-checking bench for step_count_decoder (default parameters).
module tb_step_count_decoder;
  logic        clk = 1'b0;
  logic        rst, din_vld, err_clr;
  logic [15:0] din;
  logic [15:0] idx;
  logic [1:0]  dir;
  logic        out_vld, err;
  logic [7:0]  err_cnt;
`ifdef STEP_DECODE_RUNLEN_EN
  logic [15:0] run_len;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  step_count_decoder dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .err_clr(err_clr),
    .idx(idx), .dir(dir), .out_vld(out_vld), .err(err), .err_cnt(err_cnt)
`ifdef STEP_DECODE_RUNLEN_EN
    , .run_len(run_len)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    check({tag, ".idx"},     32'(idx),     0);
    check({tag, ".dir"},     32'(dir),     3);
    check({tag, ".out_vld"}, 32'(out_vld), 0);
    check({tag, ".err"},     32'(err),     0);
    check({tag, ".err_cnt"}, 32'(err_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; din_vld = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset(tag);
  endtask

  task automatic step(input string tag, input logic [15:0] d, input logic clr,
                      input logic [15:0] ei, input logic [1:0] ed, input logic ee, input logic [7:0] ec);
    din = d; din_vld = 1'b1; err_clr = clr;
    @(posedge clk); #1;
    din_vld = 1'b0; err_clr = 1'b0;
    check({tag, ".vld"},     32'(out_vld), 1);
    check({tag, ".idx"},     32'(idx),     32'(ei));
    check({tag, ".dir"},     32'(dir),     32'(ed));
    check({tag, ".err"},     32'(err),     32'(ee));
    check({tag, ".err_cnt"}, 32'(err_cnt), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; din = '0; din_vld = 1'b0; err_clr = 1'b0;
    @(posedge clk); #1;
    do_reset("rst0");

    // up sweep, unit steps then AB=2 above the cutline
    step("up0", 16'd0, 1'b0, 16'd0, 2'b11, 1'b0, 8'd0);
    for (int i = 1; i <= 15; i++)
      step($sformatf("up%0d", i), 16'(i), 1'b0, 16'(i), 2'b01, 1'b0, 8'd0);
    step("up17", 16'd17, 1'b0, 16'd16, 2'b01, 1'b0, 8'd0);
    step("up19", 16'd19, 1'b0, 16'd17, 2'b01, 1'b0, 8'd0);

    step("dn17", 16'd17, 1'b0, 16'd16, 2'b10, 1'b0, 8'd0);
    step("dn15", 16'd15, 1'b0, 16'd15, 2'b10, 1'b0, 8'd0);
    step("dn14", 16'd14, 1'b0, 16'd14, 2'b10, 1'b0, 8'd0);
    for (int i = 13; i >= 5; i--)
      step($sformatf("dn%0d", i), 16'(i), 1'b0, 16'(i), 2'b10, 1'b0, 8'd0);
    for (int i = 0; i < 4; i++)
      step($sformatf("hold%0d", i), 16'd5, 1'b0, 16'd5, 2'b00, 1'b0, 8'd0);

    din = 16'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle%0d.vld", i), 32'(out_vld), 0);
      check($sformatf("idle%0d.idx", i), 32'(idx), 5);
    end

    do_reset("rst_top");
    step("top0", 16'd65531, 1'b0, 16'd32773, 2'b11, 1'b0, 8'd0);
    step("top1", 16'd65533, 1'b0, 16'd32774, 2'b01, 1'b0, 8'd0);
    step("top2", 16'd65535, 1'b0, 16'd32775, 2'b01, 1'b0, 8'd0);
    step("top3", 16'd65535, 1'b0, 16'd32775, 2'b00, 1'b0, 8'd0);
    step("wrap", 16'd0,     1'b0, 16'd0,     2'b11, 1'b1, 8'd1);

    do_reset("rst_ill");
    step("ill17",  16'd17, 1'b0, 16'd16, 2'b11, 1'b0, 8'd0);
    step("ill21",  16'd21, 1'b0, 16'd18, 2'b11, 1'b1, 8'd1);
    step("off20",  16'd20, 1'b0, 16'd17, 2'b11, 1'b1, 8'd2);
    step("ill21b", 16'd21, 1'b0, 16'd18, 2'b11, 1'b1, 8'd3);
    step("clr_ok", 16'd21, 1'b1, 16'd18, 2'b00, 1'b0, 8'd0);
    step("clr_ev", 16'd0,  1'b1, 16'd0,  2'b11, 1'b1, 8'd1);

    do_reset("rst_mid");
    for (int i = 0; i <= 8; i++)
      step($sformatf("mid%0d", i), 16'(i), 1'b0, 16'(i), (i == 0) ? 2'b11 : 2'b01, 1'b0, 8'd0);
    din = 16'd9; din_vld = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din_vld = 1'b0;
    chk_reset("mid_rst");
    // 40 and 42 sit off the odd grid above the cutline, so both raise an error event
    step("acq40", 16'd40, 1'b0, 16'd27, 2'b11, 1'b1, 8'd1);
    step("trk42", 16'd42, 1'b0, 16'd28, 2'b01, 1'b1, 8'd2);
    do_reset("rst_mid2");
    step("acq41", 16'd41, 1'b0, 16'd28, 2'b11, 1'b0, 8'd0);
    step("trk43", 16'd43, 1'b0, 16'd29, 2'b01, 1'b0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
